spi_reg_ctrl: RTL and testbench
===============================

# spi_reg_ctrl

SPI-slave configuration controller that owns the PWM peripheral's five 8-bit control registers. It receives 16-bit SPI write frames from an external host on three tile input pins and decodes the address. On frame completion it commits the data byte into the addressed register, which drives the PWM peripheral's configuration inputs directly. It sits between the tile's dedicated inputs and the PWM peripheral.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop stages in each input synchronizer (minimum 2).
- MAX_ADDR, 7'h04: highest writable register address; anything above is ignored.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- spi_sclk  in  1  SPI clock from host, asynchronous to clk, mode 0.
- spi_ncs  in  1  SPI chip select, active low, asynchronous.
- spi_copi  in  1  SPI data, host to controller, MSB first.
- en_reg_out_7_0  out  8  register 0x00: output enables for out[7:0].
- en_reg_out_15_8  out  8  register 0x01: output enables for out[15:8].
- en_reg_pwm_7_0  out  8  register 0x02: PWM mode enables for out[7:0].
- en_reg_pwm_15_8  out  8  register 0x03: PWM mode enables for out[15:8].
- pwm_duty_cycle  out  8  register 0x04: shared duty cycle, 0x00 = 0 %, 0xFF = 100 %.
- wr_strobe  out  1  one-cycle pulse when a register is committed.
- frame_err  out  1  one-cycle pulse when a frame is discarded.

## Operation
- Frame: exactly 16 bits. bit15 = R/W, where 1 means write. bits14:8 = address. bits7:0 = data.
- Bits are sampled on synchronized SCLK rising edges while nCS is low.
- spi_sclk, spi_ncs and spi_copi each pass through a SYNC_STAGES synchronizer.
- The SCLK and nCS synchronizers each feed an edge detector, built from one extra flop.
- COPI is delayed identically to SCLK, so bit sampling stays aligned.

State machine IDLE / SHIFT / COMMIT:
- IDLE: a falling nCS edge clears the shift register, bit_cnt and overrun, then moves to SHIFT. A level-low nCS with no falling edge does not start a frame.
- SHIFT: each SCLK rising edge shifts COPI into the LSB and increments bit_cnt, which saturates at 16. A 17th or later edge sets overrun.
- SHIFT, nCS rising edge: go to COMMIT. This applies to every edge; an SCLK edge coincident with the nCS rise is ignored.
- COMMIT, one cycle: the frame is valid if bit_cnt == 16, overrun is clear, R/W = 1 and address <= MAX_ADDR.
- COMMIT, valid frame: the addressed register is loaded with the data byte and wr_strobe pulses.
- COMMIT, invalid frame: no register changes and frame_err pulses.
- A read frame (R/W = 0) counts as invalid and pulses frame_err. Reads are not supported.
- COMMIT always returns to IDLE.
- Registers hold their value between writes. Only the addressed register ever changes.

## Timing
- Reset: all five registers = 0x00, wr_strobe = 0, frame_err = 0, state = IDLE.
- Reset values of the synchronizers: nCS stages = 1, SCLK stages = 0, COPI stages = 0.
- Reset asserted mid-frame discards the partial frame and writes no register.
- After reset is released with nCS already low, the controller waits for the next falling edge of nCS.
- Edge detect latency: SYNC_STAGES + 1 clk cycles from the pin edge to the internal edge pulse.
- Commit latency: the new register value and the strobe appear SYNC_STAGES + 2 cycles after the nCS pin rises.
- Host constraints: SCLK high and low times ≥ SYNC_STAGES + 1 clk periods each. nCS high between frames ≥ SYNC_STAGES + 2 clk periods. Violations are not detected; behaviour is undefined, but a corrupted frame must never write an address above MAX_ADDR.
- wr_strobe and frame_err are mutually exclusive and never assert for more than one cycle.

## Structure
- Package spi_reg_pkg holds:
  - the FRAME_BITS = 16 constant;
  - address constants ADDR_EN_OUT_LO = 0x00, ADDR_EN_OUT_HI = 0x01, ADDR_EN_PWM_LO = 0x02, ADDR_EN_PWM_HI = 0x03, ADDR_DUTY = 0x04;
  - the state enum {IDLE, SHIFT, COMMIT}.
- Sub-module sync_edge: a SYNC_STAGES synchronizer plus edge detect, with a reset-value parameter and outputs sync, rise and fall. It is instantiated for SCLK and nCS.
- COPI uses a plain synchronizer chain of the same depth.

## Test plan
- Reset, then write frame 0x8455 (addr 0x04, data 0x55): pwm_duty_cycle = 0x55, one wr_strobe pulse, all other registers still 0x00.
- Write frames 0x80FF, 0x8101, 0x82F0, 0x830F in sequence: registers read 0xFF, 0x01, 0xF0, 0x0F; pwm_duty_cycle unchanged.
- Frame 0x85AA (addr 0x05): no register changes, one frame_err pulse. Frame 0x0455 (read): same result.
- 15-bit frame, then 17-bit frame carrying 0x8033: both produce frame_err, and en_reg_out_7_0 is unchanged.
- Assert rst after 8 bits of 0x8277, release it with nCS still low, finish clocking the frame: no write occurs and en_reg_pwm_7_0 = 0x00. A following full 0x8277 frame then sets it to 0x77.

Source files
------------

// File: rtl/spi_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_pkg
//  Description : Shared constants and types for the SPI register controller:
//                frame length, register address map and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge
//  Description : Multi-stage synchronizer for an asynchronous input followed
//                by a single-flop edge detector.
//  Ports       : clk, rst      - system clock, async active-high reset
//                din           - asynchronous input pin
//                sync          - synchronized level
//                rise / fall   - one-cycle pulses on synchronized edges
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= {SYNC_STAGES{RST_VAL}};
            r_prev  <= RST_VAL;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], din};
            r_prev  <= r_chain[SYNC_STAGES-1];
        end
    end

    assign sync = r_chain[SYNC_STAGES-1];
    assign rise =  sync & ~r_prev;
    assign fall = ~sync &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_ctrl
//  Description : SPI-slave (mode 0, write-only) that owns the five 8-bit PWM
//                configuration registers. 16-bit frames: [15] R/W (1=write),
//                [14:8] address, [7:0] data. A frame is committed when nCS
//                rises.
//  Ports       : clk, rst                    - clock, async active-high reset
//                spi_sclk/spi_ncs/spi_copi   - asynchronous SPI pins
//                en_reg_out_7_0 .. pwm_duty_cycle - register contents
//                wr_strobe                   - pulse on register commit
//                frame_err                   - pulse on discarded frame
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_ncs,
    input  logic       spi_copi,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic       frame_err
);

    localparam int                c_SETTLE_W = $clog2(SYNC_STAGES + 2);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE = c_SETTLE_W'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]  c_FULL     = CNT_W'(FRAME_BITS);

    // ---------------- input conditioning ----------------
    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_ncs_sync, w_ncs_rise_raw, w_ncs_fall_raw;
    logic w_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk (clk), .rst (rst), .din (spi_sclk),
        .sync(w_sclk_sync), .rise(w_sclk_rise), .fall(w_sclk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs_sync (
        .clk (clk), .rst (rst), .din (spi_ncs),
        .sync(w_ncs_sync), .rise(w_ncs_rise_raw), .fall(w_ncs_fall_raw)
    );

    assign w_unused = &{1'b0, w_sclk_sync, w_sclk_fall, w_ncs_sync};

    // COPI chain has the same depth as the SCLK chain, so its output is the
    // bit that was on the pin when the synchronized SCLK rise was launched.
    logic [SYNC_STAGES-1:0] r_copi_chain;
    logic                   w_copi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_copi_chain <= '0;
        else     r_copi_chain <= {r_copi_chain[SYNC_STAGES-2:0], spi_copi};
    end
    assign w_copi = r_copi_chain[SYNC_STAGES-1];

    // The nCS chain resets high; if the pin is already low when reset is
    // released, the chain draining to 0 would look like a falling edge.
    // Edges are ignored until the chain and edge flop hold real pin samples,
    // so a frame interrupted by reset is never half-accepted.
    logic [c_SETTLE_W-1:0] r_settle_cnt;
    logic                  w_settled;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_settle_cnt <= '0;
        else if (!w_settled) r_settle_cnt <= r_settle_cnt + 1'b1;
    end
    assign w_settled = (r_settle_cnt == c_SETTLE);

    logic w_ncs_fall, w_ncs_rise;
    assign w_ncs_fall = w_ncs_fall_raw & w_settled;
    assign w_ncs_rise = w_ncs_rise_raw & w_settled;

    // ---------------- FSM ----------------
    state_t r_state, w_state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_ncs_fall) w_state_next = SHIFT;
            SHIFT:   if (w_ncs_rise) w_state_next = COMMIT;
            COMMIT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    logic [FRAME_BITS-1:0] r_shift;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_overrun;
    logic [6:0]            w_addr;
    logic                  w_frame_ok;

    assign w_addr     = r_shift[14:8];
    assign w_frame_ok = (r_bit_cnt == c_FULL) && !r_overrun &&
                        r_shift[15] && (w_addr <= MAX_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift         <= '0;
            r_bit_cnt       <= '0;
            r_overrun       <= 1'b0;
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
            wr_strobe       <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_ncs_fall) begin
                        r_shift   <= '0;
                        r_bit_cnt <= '0;
                        r_overrun <= 1'b0;
                    end
                end
                SHIFT: begin
                    // An SCLK edge coincident with the nCS rise is dropped.
                    if (w_sclk_rise && !w_ncs_rise) begin
                        r_shift <= {r_shift[FRAME_BITS-2:0], w_copi};
                        if (r_bit_cnt == c_FULL) r_overrun <= 1'b1;
                        else                     r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    if (w_frame_ok) begin
                        wr_strobe <= 1'b1;
                        case (w_addr)
                            ADDR_EN_OUT_LO: en_reg_out_7_0  <= r_shift[7:0];
                            ADDR_EN_OUT_HI: en_reg_out_15_8 <= r_shift[7:0];
                            ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= r_shift[7:0];
                            ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= r_shift[7:0];
                            ADDR_DUTY:      pwm_duty_cycle  <= r_shift[7:0];
                            default:        ;
                        endcase
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_reg_ctrl
//  Description : Self-checking bench for spi_reg_ctrl. Stimulus drives SPI
//                frames and pushes the expected outcome (strobe or error plus
//                the full register file) into a queue; a monitor pops and
//                compares on every wr_strobe / frame_err pulse and checks the
//                register file against the last committed snapshot every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_sclk, spi_ncs, spi_copi;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe, frame_err;

    always #5 clk = ~clk;

    spi_reg_ctrl #(.SYNC_STAGES(2), .MAX_ADDR(7'h04)) dut (
        .clk            (clk),
        .rst            (rst),
        .spi_sclk       (spi_sclk),
        .spi_ncs        (spi_ncs),
        .spi_copi       (spi_copi),
        .en_reg_out_7_0 (en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0 (en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle (pwm_duty_cycle),
        .wr_strobe      (wr_strobe),
        .frame_err      (frame_err)
    );

    typedef struct packed {
        logic        is_wr;
        logic [39:0] regs;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] m_regs[5];
    int         n_cmp   = 0;
    int         n_bad   = 0;
    int         n_print = 0;

    task automatic check(input string name, input logic [40:0] act, input logic [40:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            if (n_print < 30) begin
                n_print++;
                $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
            end
        end
    endtask

    function automatic logic [39:0] model_pack();
        return {m_regs[4], m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [39:0] cur_regs  = '0;
    logic        prev_wr   = 1'b0;
    logic        prev_err  = 1'b0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (rst) begin
            cur_regs = '0;
            check("reset_pulses", 41'({wr_strobe, frame_err}), 41'd0);
        end else if (wr_strobe || frame_err) begin
            check("pulse_exclusive", 41'(wr_strobe & frame_err), 41'd0);
            check("pulse_one_cycle", 41'((wr_strobe & prev_wr) | (frame_err & prev_err)), 41'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_event", 41'({wr_strobe, frame_err}), 41'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("commit_kind", 41'(wr_strobe), 41'(mon_e.is_wr));
                cur_regs = mon_e.regs;
            end
        end
        check("regs", 41'({pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                           en_reg_out_15_8, en_reg_out_7_0}), 41'(cur_regs));
        prev_wr  = wr_strobe;
        prev_err = frame_err;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clock_bit(input logic b, input int h);
        spi_copi = b;
        wait_clks(h);
        spi_sclk = 1'b1;
        wait_clks(h);
        spi_sclk = 1'b0;
    endtask

    // Sends the top nbits of a frame (nbits 15/16) or the frame plus one
    // trailing bit (nbits 17), then pushes the expected outcome.
    task automatic do_frame(input logic [15:0] f, input int nbits);
        int         h;
        logic [16:0] bits;
        logic       ok;
        h    = int'($urandom_range(4, 6));
        bits = {f, 1'($urandom_range(0, 1))};
        spi_ncs = 1'b0;
        wait_clks(h);
        for (int i = 0; i < nbits; i++) clock_bit(bits[16 - i], h);
        wait_clks(h);
        ok = (nbits == 16) && f[15] && (f[14:8] <= 7'd4);
        if (ok) m_regs[f[10:8]] = f[7:0];
        exp_q.push_back('{is_wr: ok, regs: model_pack()});
        spi_ncs = 1'b1;
        wait_clks(int'($urandom_range(6, 9)));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) wait_clks(1);
        check("queue_drain", 41'(exp_q.size()), 41'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] f;
        int          nb, r;
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        rst = 1'b1; spi_sclk = 1'b0; spi_ncs = 1'b1; spi_copi = 1'b0;
        wait_clks(4);
        rst = 1'b0;
        wait_clks(6);

        // directed sequence
        do_frame(16'h8455, 16);
        do_frame(16'h80FF, 16);
        do_frame(16'h8101, 16);
        do_frame(16'h82F0, 16);
        do_frame(16'h830F, 16);
        do_frame(16'h85AA, 16);
        do_frame(16'h0455, 16);
        do_frame(16'h8033, 15);
        do_frame(16'h8033, 17);
        wait_drain();

        // reset in the middle of a frame, released with nCS still low
        spi_ncs = 1'b0;
        wait_clks(5);
        for (int i = 15; i >= 8; i--) clock_bit(1'(16'h8277 >> i), 5);
        wait_clks(2);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(2);
        for (int i = 7; i >= 0; i--) clock_bit(1'(16'h8277 >> i), 5);
        wait_clks(5);
        spi_ncs = 1'b1;
        wait_clks(12);
        check("pwm_lo_after_reset", 41'(en_reg_pwm_7_0), 41'h00);
        do_frame(16'h8277, 16);
        wait_drain();

        // randomized frames
        for (int n = 0; n < 40; n++) begin
            r  = int'($urandom_range(0, 9));
            nb = (r == 0) ? 15 : (r == 1) ? 17 : 16;
            f  = {1'($urandom_range(0, 7) != 0), 7'($urandom_range(0, 7)), 8'($urandom)};
            do_frame(f, nb);
        end
        wait_drain();
        wait_clks(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
